muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers. Sits in the EX stage next to the single-cycle ALU.
- Executes MULT/DIV plus MADD/MSUB (accumulate into HI:LO) and MTHI/MTLO.
- Throughput per cycle is configurable by radix.
- Stalls the pipeline through alu_stall while iterating. Honours the pipeline's reg_stall/reg_flush.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_K, 2, multiplier bits retired per cycle; must divide WIDTH.
- DIV_K, 1, quotient bits retired per cycle; must divide WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reg_stall  in  1  EX stage held by another stall source
- reg_flush  in  1  kill instruction currently in EX
- alu_stall  out  1  unit busy, hold pipeline (combinational)
- op  in  3  0 NONE, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5 MADD, 6 MSUB; other codes = NONE
- sign  in  1  signed (1) or unsigned (0) operation
- source_a  in  WIDTH  rs operand / dividend / MTHI-MTLO data
- source_b  in  WIDTH  rt operand / divisor
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE, hi=0, lo=0, alu_stall=0, counter=0. rst has priority over everything; rst during BUSY aborts with no HI/LO write.
- NM = WIDTH/MUL_K, ND = WIDTH/DIV_K.
- FSM states: IDLE, BUSY, DONE.
- IDLE, op in {MULT, DIV, MADD, MSUB}, reg_flush=0:
  - alu_stall=1 combinationally in the same cycle.
  - Latch magnitudes of the operands (when sign=1), the result signs, op, and the accumulator base HI:LO.
  - Load counter with NM or ND; next state BUSY.
- DIV with source_b==0: go directly to DONE with quotient all-ones and remainder=source_a. alu_stall is high for 1 cycle.
- BUSY:
  - alu_stall=1.
  - MUL: shift-add, MUL_K bits per cycle.
  - DIV: restoring, DIV_K quotient bits per cycle.
  - Counter decrements each cycle. When counter==1, sign-correct the result and go to DONE.
- DONE:
  - alu_stall=0.
  - If reg_stall=1, hold DONE with the result unchanged and do not restart.
  - If reg_stall=0, at the clock edge write HI/LO and go to IDLE.
- Latency: alu_stall is high for exactly NM+1 (MUL/MADD/MSUB) or ND+1 (DIV) consecutive cycles. The new HI/LO is visible the cycle after DONE completes.
- Results:
  - MULT: {HI,LO} = a*b (2*WIDTH bits).
  - MADD: {HI,LO} += a*b. MSUB: {HI,LO} -= a*b. Both modulo 2^(2*WIDTH); signedness of the product follows sign.
  - DIV: LO = quotient, HI = remainder. Signed: quotient sign = sign(a) XOR sign(b), remainder takes the sign of a. Most-negative / -1 gives LO = most-negative, HI = 0.
- MTHI/MTLO (IDLE, reg_stall=0, reg_flush=0): write source_a to hi/lo at the clock edge, no stall. If reg_stall=1, no write.
- reg_flush=1 in any state:
  - Next state IDLE, no HI/LO write.
  - alu_stall=0 in that cycle.
  - Takes priority over starting, completing and MTHI/MTLO.
- An op presented while not in IDLE is ignored; the held instruction is the one in progress.

Test Plan:
- Unsigned MULT, 0xFFFFFFFF × 0xFFFFFFFF (defaults) -> alu_stall high exactly 17 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- Signed DIV, -7 / 2 -> alu_stall high 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV by 0 with a=0x1234 -> alu_stall high 1 cycle; lo=0xFFFFFFFF, hi=0x00001234.
- MTHI 0xA5A5A5A5, MTLO 1, then signed MADD 2 × -3 -> hi:lo=0xA5A5A5A4_FFFFFFFB. MSUB with the same operands restores 0xA5A5A5A5_00000001.
- MULT 5×7, reg_flush pulsed at BUSY cycle 4 -> alu_stall low in the flush cycle; hi/lo unchanged. A following MULT 3×3 gives lo=9.
- MULT 5×7 with reg_stall=1 for 3 cycles in DONE -> hi/lo stay old while held, no restart. lo=35 the cycle after reg_stall drops.
- Sweep MUL_K=1/4/8 and DIV_K=2 -> stall cycles = WIDTH/K+1 each; results match the K=default results.

Source files
------------

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative multiply/divide unit with architectural HI/LO registers
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int MUL_K = 2,
   parameter int DIV_K = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reg_stall,
   input  logic             reg_flush,
   output logic             alu_stall,
   input  logic [2:0]       op,
   input  logic             sign,
   input  logic [WIDTH-1:0] source_a,
   input  logic [WIDTH-1:0] source_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int NM = WIDTH / MUL_K;
   localparam int ND = WIDTH / DIV_K;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [2:0] OP_MULT = 3'd1, OP_DIV = 3'd2, OP_MTHI = 3'd3, OP_MTLO = 3'd4, OP_MADD = 3'd5, OP_MSUB = 3'd6;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] u, l, d, abs_a, abs_b, mu_n, ml_n, dr, dq, q_f, r_f;
   logic [WIDTH+MUL_K-1:0] msum;
   logic [WIDTH:0] rr;
   logic [2*WIDTH-1:0] prod, mres;
   logic [2:0] op_q;
   logic neg_q, neg_r, start, ge, b_zero, last, div_q, idle_wr;

   assign start   = state == IDLE && !reg_flush && (op == OP_MULT || op == OP_DIV || op == OP_MADD || op == OP_MSUB);
   assign idle_wr = state == IDLE && !reg_flush && !reg_stall;
   assign b_zero  = source_b == '0;
   assign abs_a   = sign && source_a[WIDTH-1] ? -source_a : source_a;
   assign abs_b   = sign && source_b[WIDTH-1] ? -source_b : source_b;
   assign last    = cnt == CW'(1);
   assign div_q   = op_q == OP_DIV;
   // u holds the running high half (product) or partial remainder; l the multiplier or dividend/quotient
   assign msum    = {{MUL_K{1'b0}}, u} + ({{MUL_K{1'b0}}, d} * {{WIDTH{1'b0}}, l[MUL_K-1:0]});
   assign mu_n    = msum[WIDTH+MUL_K-1:MUL_K];
   assign ml_n    = {msum[MUL_K-1:0], l[WIDTH-1:MUL_K]};
   assign prod    = neg_q ? -{mu_n, ml_n} : {mu_n, ml_n};
   assign mres    = op_q == OP_MADD ? {hi, lo} + prod : op_q == OP_MSUB ? {hi, lo} - prod : prod;
   assign q_f     = neg_q ? -dq : dq;
   assign r_f     = neg_r ? -dr : dr;

   // restoring division, DIV_K quotient bits per cycle
   always_comb begin
      dr = u;
      dq = l;
      rr = '0;
      ge = 1'b0;
      for (int i = 0; i < DIV_K; i++) begin
         rr = {dr, dq[WIDTH-1]};
         ge = rr >= {1'b0, d};
         rr = ge ? rr - {1'b0, d} : rr;
         dq = {dq[WIDTH-2:0], ge};
         dr = rr[WIDTH-1:0];
      end
   end

   // next state and pipeline stall; a flush always wins
   always_comb begin
      state_n   = reg_flush ? IDLE :
                  state == IDLE ? (start ? (op == OP_DIV && b_zero ? DONE : BUSY) : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) :
                  (reg_stall ? DONE : IDLE);
      alu_stall = start || (state == BUSY && !reg_flush);
   end

   // operand capture, iteration, and architectural HI/LO updates
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         u     <= '0;
         l     <= '0;
         d     <= '0;
         op_q  <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_n;
         if (start) begin
            op_q  <= op;
            neg_q <= sign && (source_a[WIDTH-1] ^ source_b[WIDTH-1]);
            neg_r <= sign && source_a[WIDTH-1];
            d     <= op == OP_DIV ? abs_b : abs_a;
            l     <= op == OP_DIV ? (b_zero ? '1 : abs_a) : abs_b;
            u     <= op == OP_DIV && b_zero ? source_a : '0;
            cnt   <= op == OP_DIV ? CW'(ND) : CW'(NM);
         end else if (state == BUSY) begin
            cnt    <= cnt - CW'(1);
            {u, l} <= last ? (div_q ? {r_f, q_f} : mres) : (div_q ? {dr, dq} : {mu_n, ml_n});
         end
         if (state == DONE && !reg_flush && !reg_stall) {hi, lo} <= {u, l};
         if (idle_wr && op == OP_MTHI) hi <= source_a;
         if (idle_wr && op == OP_MTLO) lo <= source_a;
      end
   end
endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed checks of muldiv_iter across several radix configurations
module tb_muldiv_iter;
   logic clk = 1'b0;
   logic rst, reg_stall, reg_flush, sgn;
   logic [31:0] sa, sb;
   logic [2:0] op_v [4];
   logic stall_v [4];
   logic [31:0] hi_v [4], lo_v [4];
   int n_chk = 0, n_fail = 0, n;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      muldiv_iter #(
         .WIDTH(32),
         .MUL_K(g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 8),
         .DIV_K(g == 1 ? 2 : 1)
      ) dut (
         .clk(clk), .rst(rst), .reg_stall(reg_stall), .reg_flush(reg_flush),
         .alu_stall(stall_v[g]), .op(op_v[g]), .sign(sgn),
         .source_a(sa), .source_b(sb), .hi(hi_v[g]), .lo(lo_v[g])
      );
   end

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic        s;
      logic [31:0] a, b, ehi, elo;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int exp_stall(input int g, input logic [2:0] o, input logic [31:0] b);
      int mk, dk;
      mk = g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 4 : 8;
      dk = g == 1 ? 2 : 1;
      return o == 3'd2 ? (b == 0 ? 1 : 32 / dk + 1) : 32 / mk + 1;
   endfunction

   task automatic run(input int i, input logic [2:0] o, input logic s, input logic [31:0] a, input logic [31:0] b, output int cyc);
      @(negedge clk);
      op_v[i] = o; sgn = s; sa = a; sb = b; cyc = 0;
      #1;
      while (stall_v[i] && cyc < 200) begin
         cyc++;
         @(negedge clk);
         #1;
      end
      op_v[i] = 3'd0;
      @(negedge clk);
      #1;
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      @(negedge clk);
      op_v[0] = o; sa = a;
      #1;
      chk("mt_stall", 32'(stall_v[0]), 0);
      @(negedge clk);
      op_v[0] = 3'd0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v [9];
      v[0] = '{"mult_u_max",  3'd1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      v[1] = '{"div_s_m7_2",  3'd2, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[2] = '{"div_s_ovf",   3'd2, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      v[3] = '{"div_by_zero", 3'd2, 1'b0, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
      v[4] = '{"mult_s_m3_5", 3'd1, 1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      v[5] = '{"div_u_100_7", 3'd2, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14};
      v[6] = '{"mult_u_sh",   3'd1, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
      v[7] = '{"div_s_7_m2",  3'd2, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      v[8] = '{"div_u_big",   3'd2, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
      rst = 1'b1; reg_stall = 1'b0; reg_flush = 1'b0; sgn = 1'b0; sa = '0; sb = '0;
      for (int i = 0; i < 4; i++) op_v[i] = 3'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_hi%0d", i), hi_v[i], 0);
         chk($sformatf("reset_lo%0d", i), lo_v[i], 0);
         chk($sformatf("reset_stall%0d", i), 32'(stall_v[i]), 0);
      end
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 9; k++) begin
            run(i, v[k].op, v[k].s, v[k].a, v[k].b, n);
            chk($sformatf("%s_cyc%0d", v[k].name, i), n, exp_stall(i, v[k].op, v[k].b));
            chk($sformatf("%s_hi%0d", v[k].name, i), hi_v[i], v[k].ehi);
            chk($sformatf("%s_lo%0d", v[k].name, i), lo_v[i], v[k].elo);
         end
      mt(3'd3, 32'hA5A5A5A5);
      mt(3'd4, 32'h00000001);
      chk("mthi", hi_v[0], 32'hA5A5A5A5);
      chk("mtlo", lo_v[0], 32'h00000001);
      run(0, 3'd5, 1'b1, 32'd2, 32'hFFFFFFFD, n);
      chk("madd_cyc", n, 17);
      chk("madd_hi", hi_v[0], 32'hA5A5A5A4);
      chk("madd_lo", lo_v[0], 32'hFFFFFFFB);
      run(0, 3'd6, 1'b1, 32'd2, 32'hFFFFFFFD, n);
      chk("msub_cyc", n, 17);
      chk("msub_hi", hi_v[0], 32'hA5A5A5A5);
      chk("msub_lo", lo_v[0], 32'h00000001);
      reg_stall = 1'b1;
      mt(3'd3, 32'hDEADBEEF);
      reg_stall = 1'b0;
      chk("mthi_held", hi_v[0], 32'hA5A5A5A5);
      @(negedge clk);
      op_v[0] = 3'd1; sgn = 1'b0; sa = 32'd5; sb = 32'd7;
      #1;
      chk("flush_start_stall", 32'(stall_v[0]), 1);
      repeat (4) @(negedge clk);
      reg_flush = 1'b1; op_v[0] = 3'd0;
      #1;
      chk("flush_stall", 32'(stall_v[0]), 0);
      @(negedge clk);
      reg_flush = 1'b0;
      #1;
      chk("flush_after_stall", 32'(stall_v[0]), 0);
      chk("flush_hi", hi_v[0], 32'hA5A5A5A5);
      chk("flush_lo", lo_v[0], 32'h00000001);
      run(0, 3'd1, 1'b0, 32'd3, 32'd3, n);
      chk("post_flush_cyc", n, 17);
      chk("post_flush_hi", hi_v[0], 0);
      chk("post_flush_lo", lo_v[0], 9);
      @(negedge clk);
      op_v[0] = 3'd1; sgn = 1'b0; sa = 32'd5; sb = 32'd7; n = 0;
      #1;
      while (stall_v[0] && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk("hold_cyc", n, 17);
      reg_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk("hold_stall", 32'(stall_v[0]), 0);
         chk("hold_lo", lo_v[0], 9);
         chk("hold_hi", hi_v[0], 0);
      end
      reg_stall = 1'b0; op_v[0] = 3'd0;
      @(negedge clk);
      #1;
      chk("hold_done_lo", lo_v[0], 35);
      chk("hold_done_hi", hi_v[0], 0);
      chk("hold_done_stall", 32'(stall_v[0]), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
